// File: rtl/scene_sequencer.sv
// -----------------------------------------------------------------------------
// scene_sequencer
// Game-flow scheduler on the animation tick. It plays the dog intro, launches
// ducks one at a time, tallies hits per round, and decides round advance or
// game over.
//
// Ports
//   ANIM_Clk      in   animation tick clock
//   Reset         in   asynchronous, active-high
//   Start         in   start/restart request (honoured in IDLE and OVER only)
//   Dog_Done      in   dog_control is in its hold state
//   Duck_Hit      in   current duck shot
//   Duck_Escaped  in   current duck left the screen
//   Dog_Run       out  Run level to dog_control (high in INTRO)
//   Duck_Launch   out  one-tick launch strobe
//   Round[3:0]    out  current round, 1-based
//   Duck_Idx[3:0] out  ducks launched this round
//   Hits[3:0]     out  hits this round
//   Last_Hit      out  result of the most recent duck
//   Scene[2:0]    out  state code for sprite/HUD muxing
//   Game_Over     out  high in OVER
//   Win           out  high in OVER when every round was cleared
//
// Build option
//   SCENE_INTRO_ONCE_EN  when defined, the intro plays only before round 1;
//                        later rounds go RND_END -> LAUNCH directly.
// -----------------------------------------------------------------------------
module scene_sequencer #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int NUM_ROUNDS      = 5,
  parameter int MIN_HITS        = 6,
  parameter int INTRO_TIMEOUT   = 255,
  parameter int FLIGHT_TIMEOUT  = 200,
  parameter int RESULT_TICKS    = 16
) (
  input  logic       ANIM_Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Dog_Done,
  input  logic       Duck_Hit,
  input  logic       Duck_Escaped,
  output logic       Dog_Run,
  output logic       Duck_Launch,
  output logic [3:0] Round,
  output logic [3:0] Duck_Idx,
  output logic [3:0] Hits,
  output logic       Last_Hit,
  output logic [2:0] Scene,
  output logic       Game_Over,
  output logic       Win
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INTRO   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_FLIGHT  = 3'd3,
    S_RESULT  = 3'd4,
    S_RND_END = 3'd5,
    S_OVER    = 3'd6
  } state_t;

  localparam logic [3:0] DPR      = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0] NRND     = 4'(NUM_ROUNDS);
  localparam logic [3:0] MINH     = 4'(MIN_HITS);
  localparam logic [7:0] INTRO_TO = 8'(INTRO_TIMEOUT);
  localparam logic [7:0] FLT_TO   = 8'(FLIGHT_TIMEOUT);
  // tmr is 0 on entry, so the last RESULT tick is RESULT_TICKS-1
  localparam logic [7:0] RES_LAST = 8'(RESULT_TICKS - 1);

  state_t     state, nxt;
  logic [7:0] tmr;
  logic       dog_run_d, launch_d, over_d;

  // state register plus the registered decode outputs
  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      Dog_Run     <= 1'b0;
      Duck_Launch <= 1'b0;
      Game_Over   <= 1'b0;
    end else begin
      state       <= nxt;
      Dog_Run     <= dog_run_d;
      Duck_Launch <= launch_d;
      Game_Over   <= over_d;
    end
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (Start) nxt = S_INTRO;
      S_INTRO:   if (Dog_Done || tmr == INTRO_TO) nxt = S_LAUNCH;
      S_LAUNCH:  nxt = S_FLIGHT;
      S_FLIGHT:  if (Duck_Hit || Duck_Escaped || tmr == FLT_TO) nxt = S_RESULT;
      S_RESULT:  if (tmr == RES_LAST) nxt = (Duck_Idx < DPR) ? S_LAUNCH : S_RND_END;
      S_RND_END: begin
        if (Hits < MINH || Round == NRND) nxt = S_OVER;
`ifdef SCENE_INTRO_ONCE_EN
        else                              nxt = S_LAUNCH;
`else
        else                              nxt = S_INTRO;
`endif
      end
      S_OVER:    if (Start) nxt = S_INTRO;
      default:   nxt = S_IDLE;
    endcase
  end

  // output decode from the next state so the registered outputs change in
  // the same tick as the state (Dog_Run drops on the INTRO->LAUNCH edge)
  always_comb begin
    dog_run_d = (nxt == S_INTRO);
    launch_d  = (nxt == S_LAUNCH);
    over_d    = (nxt == S_OVER);
  end

  assign Scene = state;

  // tick timer and game counters
  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      tmr      <= 8'd0;
      Round    <= 4'd1;
      Duck_Idx <= 4'd0;
      Hits     <= 4'd0;
      Last_Hit <= 1'b0;
      Win      <= 1'b0;
    end else begin
      if (nxt != state)     tmr <= 8'd0;
      else if (tmr != 8'hFF) tmr <= tmr + 8'd1;

      case (state)
        S_IDLE, S_OVER: begin
          if (nxt == S_INTRO) begin
            Round    <= 4'd1;
            Duck_Idx <= 4'd0;
            Hits     <= 4'd0;
            Last_Hit <= 1'b0;
            Win      <= 1'b0;
          end
        end
        S_INTRO, S_RESULT: begin
          if (nxt == S_LAUNCH) Duck_Idx <= Duck_Idx + 4'd1;
        end
        S_FLIGHT: begin
          // a hit outranks a simultaneous escape
          if (Duck_Hit) begin
            Last_Hit <= 1'b1;
            Hits     <= Hits + 4'd1;
          end else if (nxt == S_RESULT) begin
            Last_Hit <= 1'b0;
          end
        end
        S_RND_END: begin
          if (nxt == S_OVER) begin
            Win <= (Hits >= MINH);
          end else begin
            Round <= Round + 4'd1;
            Hits  <= 4'd0;
            // skipping the intro means this edge is also the first launch
            Duck_Idx <= (nxt == S_LAUNCH) ? 4'd1 : 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
module tb_scene_sequencer;
  logic       ANIM_Clk = 1'b0;
  logic       Reset, Start, Dog_Done, Duck_Hit, Duck_Escaped;
  logic       Dog_Run, Duck_Launch, Last_Hit, Game_Over, Win;
  logic [3:0] Round, Duck_Idx, Hits;
  logic [2:0] Scene;

  scene_sequencer dut (
    .ANIM_Clk(ANIM_Clk), .Reset(Reset), .Start(Start), .Dog_Done(Dog_Done),
    .Duck_Hit(Duck_Hit), .Duck_Escaped(Duck_Escaped), .Dog_Run(Dog_Run),
    .Duck_Launch(Duck_Launch), .Round(Round), .Duck_Idx(Duck_Idx), .Hits(Hits),
    .Last_Hit(Last_Hit), .Scene(Scene), .Game_Over(Game_Over), .Win(Win)
  );

  always #5 ANIM_Clk = ~ANIM_Clk;

  typedef struct {
    logic       last;
    logic [3:0] hits;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   m_round, m_hits, m_idx;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge ANIM_Clk);
    #1;
  endtask

  task automatic wait_scene(input int s, input string tag);
    int n = 0;
    while (Scene != 3'(s) && n < 600) begin
      tick;
      n++;
    end
    chk(tag, Scene, s);
  endtask

  task automatic start_game;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    m_round = 1; m_hits = 0; m_idx = 0;
    chk("start_scene", Scene, 1);
    chk("start_round", Round, 1);
    chk("start_hits", Hits, 0);
    chk("start_idx", Duck_Idx, 0);
    chk("start_win", Win, 0);
    chk("start_over", Game_Over, 0);
  endtask

  // k = 0: never raise Dog_Done, expect the timeout
  task automatic run_intro(input int k, input string tag);
    int cnt = 0, runs = 0;
    while (Scene == 3'd1 && cnt < 400) begin
      cnt++;
      if (Dog_Run) runs++;
      if (k != 0 && cnt == k) Dog_Done = 1'b1;
      tick;
    end
    Dog_Done = 1'b0;
    chk(tag, runs, (k == 0) ? 256 : k);
    chk("dog_run_drop", Dog_Run, 0);
  endtask

  // oc: 0 hit, 1 escape, 2 hit+escape, 3 timeout
  task automatic play_duck(input int oc);
    exp_t e;
    int   cnt;
    wait_scene(2, "scene_launch");
    m_idx++;
    chk("launch", Duck_Launch, 1);
    chk("duck_idx", Duck_Idx, m_idx);
    tick;
    chk("launch_1tick", Duck_Launch, 0);
    chk("scene_flight", Scene, 3);
    case (oc)
      0: begin Duck_Hit = 1'b1; m_hits++; e.last = 1'b1; end
      1: begin Duck_Escaped = 1'b1; e.last = 1'b0; end
      2: begin Duck_Hit = 1'b1; Duck_Escaped = 1'b1; m_hits++; e.last = 1'b1; end
      default: e.last = 1'b0;
    endcase
    e.hits = 4'(m_hits);
    sb.push_back(e);
    if (oc == 3) begin
      // flight entry tick already observed; Start pulse must be ignored here
      cnt = 1;
      while (Scene == 3'd3 && cnt < 400) begin
        Start = (cnt == 5);
        tick;
        if (Scene == 3'd3) cnt++;
      end
      Start = 1'b0;
      chk("flight_len", cnt, 201);
    end else begin
      tick;
    end
    Duck_Hit = 1'b0; Duck_Escaped = 1'b0;
    e = sb.pop_front();
    chk("scene_result", Scene, 4);
    chk("last_hit", Last_Hit, e.last);
    chk("hits", Hits, e.hits);
    // a hit while showing the result must not count
    cnt = 0;
    while (Scene == 3'd4 && cnt < 100) begin
      Duck_Hit = (cnt == 0);
      cnt++;
      tick;
    end
    Duck_Hit = 1'b0;
    chk("result_len", cnt, 16);
  endtask

  task automatic play_round(input logic [9:0] mask, input bit special);
    int oc;
    for (int d = 0; d < 10; d++) begin
      oc = mask[d] ? 0 : 1;
      if (special && d == 0) oc = 2;
      if (special && d == 1) oc = 3;
      play_duck(oc);
    end
    wait_scene(5, "scene_rnd_end");
    chk("rnd_end_hits", Hits, m_hits);
    tick;
    if (m_hits < 6) begin
      chk("lose_scene", Scene, 6);
      chk("lose_over", Game_Over, 1);
      chk("lose_win", Win, 0);
    end else if (m_round == 5) begin
      chk("win_scene", Scene, 6);
      chk("win_over", Game_Over, 1);
      chk("win_win", Win, 1);
    end else begin
      m_round++; m_hits = 0; m_idx = 0;
      chk("next_round", Round, m_round);
      chk("next_hits", Hits, 0);
`ifdef SCENE_INTRO_ONCE_EN
      chk("skip_intro_scene", Scene, 2);
      chk("skip_intro_dog", Dog_Run, 0);
`else
      chk("next_intro_scene", Scene, 1);
      chk("next_idx", Duck_Idx, 0);
      chk("next_dog_run", Dog_Run, 1);
`endif
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Dog_Done = 1'b0; Duck_Hit = 1'b0; Duck_Escaped = 1'b0;
    repeat (3) tick;
    chk("rst_scene", Scene, 0);
    chk("rst_round", Round, 1);
    chk("rst_idx", Duck_Idx, 0);
    chk("rst_hits", Hits, 0);
    chk("rst_last", Last_Hit, 0);
    chk("rst_dog", Dog_Run, 0);
    chk("rst_launch", Duck_Launch, 0);
    chk("rst_over", Game_Over, 0);
    chk("rst_win", Win, 0);
    Reset = 1'b0;
    Duck_Hit = 1'b1;
    repeat (2) tick;
    Duck_Hit = 1'b0;
    chk("idle_hold", Scene, 0);
    chk("idle_hits", Hits, 0);

    // game 1: clear all rounds, round 1 at exactly MIN_HITS
    start_game;
    run_intro(40, "intro_40");
    play_round(10'b0001111101, 1'b1);
    for (int r = 2; r <= 5; r++) begin
`ifndef SCENE_INTRO_ONCE_EN
      run_intro(8 + r, "intro_short");
`endif
      play_round(10'h3FF, 1'b0);
    end
    repeat (3) tick;
    chk("over_hold_win", Win, 1);

    // game 2: intro timeout, then a round one hit short
    start_game;
    run_intro(0, "intro_timeout");
    play_round(10'b0000011111, 1'b0);

    // game 3: reset in the middle of a flight
    start_game;
    run_intro(3, "intro_3");
    wait_scene(2, "scene_launch");
    repeat (3) tick;
    chk("pre_reset_flight", Scene, 3);
    Reset = 1'b1;
    tick;
    chk("mid_rst_scene", Scene, 0);
    chk("mid_rst_round", Round, 1);
    chk("mid_rst_launch", Duck_Launch, 0);
    chk("mid_rst_dog", Dog_Run, 0);
    chk("mid_rst_idx", Duck_Idx, 0);
    Reset = 1'b0;
    tick;
    chk("post_rst_idle", Scene, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
